wb_rr_master_arbiter: RTL

// - Shares the MAC's single Wishbone config/status slave port between NUM_REQ requesters.

---
 rtl/wb_rr_master_arbiter.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/wb_rr_master_arbiter.sv
// wb_rr_master_arbiter: round-robin arbiter that shares one classic Wishbone slave port
// between NUM_REQ requesters, one single-beat transaction at a time.
// Optional bus timeout abort is compiled in when WB_ARB_TIMEOUT_EN is defined.
module wb_rr_master_arbiter #(
    parameter int unsigned NUM_REQ     = 2,
    parameter int unsigned ADR_W       = 8,
    parameter int unsigned DAT_W       = 32,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    input  logic [NUM_REQ-1:0]       req_we_i,
    input  logic [NUM_REQ*ADR_W-1:0] req_adr_i,
    input  logic [NUM_REQ*DAT_W-1:0] req_wdat_i,
    output logic [NUM_REQ-1:0]       req_ack_o,
    output logic [NUM_REQ-1:0]       req_err_o,
    output logic [DAT_W-1:0]         req_rdat_o,
    output logic [NUM_REQ-1:0]       grant_o,
    output logic                     busy_o,
    output logic [ADR_W-1:0]         wb_adr_o,
    output logic [DAT_W-1:0]         wb_dat_o,
    output logic                     wb_we_o,
    output logic                     wb_stb_o,
    output logic                     wb_cyc_o,
    input  logic [DAT_W-1:0]         wb_dat_i,
    input  logic                     wb_ack_i
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [NUM_REQ-1:0] err_q, err_d;
    logic [DAT_W-1:0]   rdat_q, rdat_d;
    logic [ADR_W-1:0]   adr_q, adr_d;
    logic [DAT_W-1:0]   dat_q, dat_d;
    logic               we_q, we_d;
    logic               cyc_q, cyc_d;
    logic               busy_q, busy_d;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    logic unused_cfg;
    assign unused_cfg = |TIMEOUT_CYC;
`endif

    logic [PTR_W-1:0]   win_c;
    logic               found_c;
    logic [ADR_W-1:0]   win_adr_c;
    logic [DAT_W-1:0]   win_dat_c;
    logic               win_we_c;

    // Round-robin search: first valid index at or above ptr, else first valid from 0.
    always_comb begin
        win_c   = '0;
        found_c = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found_c && req_valid_i[i] && (PTR_W'(i) >= ptr_q)) begin
                found_c = 1'b1;
                win_c   = PTR_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found_c && req_valid_i[i]) begin
                found_c = 1'b1;
                win_c   = PTR_W'(i);
            end
        end
    end

    // Select the winning requester's transaction fields.
    always_comb begin
        win_adr_c = '0;
        win_dat_c = '0;
        win_we_c  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (PTR_W'(i) == win_c) begin
                win_adr_c = req_adr_i[i*ADR_W +: ADR_W];
                win_dat_c = req_wdat_i[i*DAT_W +: DAT_W];
                win_we_c  = req_we_i[i];
            end
        end
    end

    // Next-state and registered-output logic for IDLE -> BUS -> GAP -> IDLE.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        we_d    = we_q;
        cyc_d   = cyc_q;
        ack_d   = '0;
        err_d   = '0;
        rdat_d  = '0;
`ifdef WB_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|req_valid_i) begin
                    adr_d   = win_adr_c;
                    dat_d   = win_dat_c;
                    we_d    = win_we_c;
                    grant_d = NUM_REQ'(1) << win_c;
                    cyc_d   = 1'b1;
                    ptr_d   = (win_c == PTR_W'(NUM_REQ - 1)) ? '0 : win_c + PTR_W'(1);
                    state_d = ST_BUS;
`ifdef WB_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ST_BUS: begin
                if (wb_ack_i) begin
                    cyc_d   = 1'b0;
                    ack_d   = grant_q;
                    rdat_d  = we_q ? '0 : wb_dat_i;
                    state_d = ST_GAP;
                end
`ifdef WB_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    cyc_d   = 1'b0;
                    ack_d   = grant_q;
                    err_d   = grant_q;
                    state_d = ST_GAP;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
`endif
            end
            ST_GAP: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                grant_d = '0;
                cyc_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset drops any transaction in flight immediately.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            ack_q   <= '0;
            err_q   <= '0;
            rdat_q  <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            we_q    <= 1'b0;
            cyc_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdat_q  <= rdat_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            we_q    <= we_d;
            cyc_q   <= cyc_d;
            busy_q  <= busy_d;
`ifdef WB_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign req_ack_o  = ack_q;
    assign req_err_o  = err_q;
    assign req_rdat_o = rdat_q;
    assign grant_o    = grant_q;
    assign busy_o     = busy_q;
    assign wb_adr_o   = adr_q;
    assign wb_dat_o   = dat_q;
    assign wb_we_o    = we_q;
    assign wb_stb_o   = cyc_q;
    assign wb_cyc_o   = cyc_q;

endmodule
